// File: rtl/compress_shift_ctrl.sv
// Block-floating-point shift scheduler: per-packet peak magnitude -> safe left shift for compress_shift.
// Latency: shift loaded exactly DLY_CYCLE+APPLY_OFS cycles after the packet's sop; peak ready 2 cycles after eop.
// Backpressure: none; the input bus is never stalled, a full queue drops the packet and pulses o_err_ovf.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (deassertion synchronised internally)
//   i_sop/i_eop/i_vld   packet framing shared with the compressor input bus
//   i_din_re/i_din_im   IW-bit two's complement samples
//   i_man_en/i_man_shift manual shift override, captured with sop
//   o_shift_num         shift value for the compressor, held between updates
//   o_shift_upd         1-cycle pulse in the cycle o_shift_num takes a new value
//   o_q_level           occupied schedule queue entries
//   o_err_ovf/late/proto single-cycle error pulses
module compress_shift_ctrl #(
  parameter int IW        = 40,
  parameter int OW        = 16,
  parameter int DLY_CYCLE = 1584,
  parameter int APPLY_OFS = 1,
  parameter int QDEPTH    = 4,
  parameter int TSW       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sop,
  input  logic                      i_eop,
  input  logic                      i_vld,
  input  logic [IW-1:0]             i_din_re,
  input  logic [IW-1:0]             i_din_im,
  input  logic                      i_man_en,
  input  logic [4:0]                i_man_shift,
  output logic [4:0]                o_shift_num,
  output logic                      o_shift_upd,
  output logic [$clog2(QDEPTH):0]   o_q_level,
  output logic                      o_err_ovf,
  output logic                      o_err_late,
  output logic                      o_err_proto
);

  localparam int              QW        = $clog2(QDEPTH);
  localparam int              LZW       = $clog2(IW);
  localparam logic [4:0]      MAX_SHIFT = 5'(IW - OW);
  localparam logic [TSW-1:0]  DUE_DIST  = TSW'(DLY_CYCLE + APPLY_OFS);
  localparam logic [TSW-1:0]  TS_ONE    = TSW'(1);
  localparam logic [QW:0]     PTR_ONE   = (QW + 1)'(1);
  localparam logic [QW:0]     Q_FULL    = (QW + 1)'(QDEPTH);
  localparam logic [LZW-1:0]  LZ_ONE    = LZW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two clocks after rst_n rises.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int_n;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= 2'b00;
    else        rst_pipe_q <= rst_pipe_d;
  end

  assign rst_int_n = rst_pipe_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [TSW-1:0]    ts_q, ts_d;
  logic [IW-2:0]     acc_q, acc_d;

  // packet currently being scanned
  logic [QW-1:0]     open_idx_q, open_idx_d;
  logic              open_live_q, open_live_d;
  logic              open_man_q, open_man_d;
  logic [4:0]        open_mshift_q, open_mshift_d;

  // finished packet waiting for its shift to be written into the queue
  logic              fin_q, fin_d;
  logic [QW-1:0]     fin_idx_q, fin_idx_d;
  logic              fin_live_q, fin_live_d;
  logic              fin_man_q, fin_man_d;
  logic [4:0]        fin_mshift_q, fin_mshift_d;
  logic [IW-2:0]     fin_acc_q, fin_acc_d;

  // schedule queue
  logic [TSW-1:0]    q_stamp_q [QDEPTH];
  logic [TSW-1:0]    q_stamp_d [QDEPTH];
  logic [4:0]        q_shift_q [QDEPTH];
  logic [4:0]        q_shift_d [QDEPTH];
  logic [QDEPTH-1:0] q_rdy_q, q_rdy_d;
  logic [QW:0]       wr_ptr_q, wr_ptr_d;
  logic [QW:0]       rd_ptr_q, rd_ptr_d;

  // registered outputs
  logic [4:0]        shift_num_q, shift_num_d;
  logic              upd_q, upd_d;
  logic              ovf_q, ovf_d;
  logic              late_q, late_d;
  logic              proto_q, proto_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  function automatic logic [LZW-1:0] f_lzc(input logic [IW-2:0] v);
    logic [LZW-1:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int i = IW - 2; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + LZ_ONE;
      end
    end
    return n;
  endfunction

  logic           sop_v, eop_v;
  logic [IW-2:0]  samp_mag;
  logic [QW:0]    level;
  logic           q_full, q_empty;
  logic [QW-1:0]  rd_idx, wr_idx;
  logic [TSW-1:0] age;
  logic           due;
  logic           kill_open, kill_fin;
  logic           open_live_eff;
  logic [LZW-1:0] fin_lz;
  logic [4:0]     fin_auto, fin_shift;
  logic [4:0]     man_clip;

  always_comb begin
    sop_v = i_vld & i_sop;
    eop_v = i_vld & i_eop;

    // one's-complement magnitude; the sign bit itself is dropped
    samp_mag = (i_din_re[IW-2:0] ^ {(IW-1){i_din_re[IW-1]}})
             | (i_din_im[IW-2:0] ^ {(IW-1){i_din_im[IW-1]}});

    level   = wr_ptr_q - rd_ptr_q;
    q_full  = (level == Q_FULL);
    q_empty = (level == '0);
    rd_idx  = rd_ptr_q[QW-1:0];
    wr_idx  = wr_ptr_q[QW-1:0];

    // Evaluated against next cycle's timestamp so the registered shift
    // becomes visible exactly DLY_CYCLE+APPLY_OFS cycles after sop.
    age = ts_q + TS_ONE - q_stamp_q[rd_idx];
    due = !q_empty && (age == DUE_DIST);

    // A pop of an entry whose peak is still being gathered makes any later
    // update for it meaningless; these flags discard it.
    kill_open     = due && (rd_idx == open_idx_q);
    kill_fin      = due && (rd_idx == fin_idx_q);
    open_live_eff = open_live_q & ~kill_open;

    fin_lz = f_lzc(fin_acc_q);
    if (int'(fin_lz) > int'(MAX_SHIFT)) fin_auto = MAX_SHIFT;
    else                                fin_auto = 5'(fin_lz);
    fin_shift = fin_man_q ? fin_mshift_q : fin_auto;

    man_clip = (i_man_shift > MAX_SHIFT) ? MAX_SHIFT : i_man_shift;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic alloc_live;

  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + TS_ONE;
    acc_d         = acc_q;
    open_idx_d    = open_idx_q;
    open_live_d   = open_live_eff;
    open_man_d    = open_man_q;
    open_mshift_d = open_mshift_q;
    fin_d         = 1'b0;
    fin_idx_d     = fin_idx_q;
    fin_live_d    = fin_live_q;
    fin_man_d     = fin_man_q;
    fin_mshift_d  = fin_mshift_q;
    fin_acc_d     = fin_acc_q;
    q_stamp_d     = q_stamp_q;
    q_shift_d     = q_shift_q;
    q_rdy_d       = q_rdy_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    shift_num_d   = shift_num_q;
    upd_d         = 1'b0;
    ovf_d         = 1'b0;
    late_d        = 1'b0;
    proto_d       = 1'b0;
    alloc_live    = 1'b0;

    // due: pop head and present its shift (0 if the peak never arrived)
    if (due) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      upd_d    = 1'b1;
      if (q_rdy_q[rd_idx]) begin
        shift_num_d = q_shift_q[rd_idx];
      end else begin
        shift_num_d = '0;
        late_d      = 1'b1;
      end
    end

    // finished peak from the previous cycle lands in its entry
    if (fin_q && fin_live_q && !kill_fin) begin
      q_shift_d[fin_idx_q] = fin_shift;
      q_rdy_d[fin_idx_q]   = 1'b1;
    end

    // allocation on any valid sop; fullness is judged before this cycle's pop
    if (sop_v) begin
      if (q_full) begin
        ovf_d = 1'b1;
      end else begin
        q_stamp_d[wr_idx] = ts_q;
        q_rdy_d[wr_idx]   = 1'b0;
        wr_ptr_d          = wr_ptr_q + PTR_ONE;
        alloc_live        = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sop_v) begin
          acc_d         = samp_mag;
          open_idx_d    = wr_idx;
          open_live_d   = alloc_live;
          open_man_d    = i_man_en;
          open_mshift_d = man_clip;
          if (eop_v) begin
            fin_d        = 1'b1;
            fin_idx_d    = wr_idx;
            fin_live_d   = alloc_live;
            fin_man_d    = i_man_en;
            fin_mshift_d = man_clip;
            fin_acc_d    = samp_mag;
            open_live_d  = 1'b0;
          end else begin
            state_d = S_SCAN;
          end
        end else if (eop_v) begin
          proto_d = 1'b1;
        end
      end

      S_SCAN: begin
        if (sop_v) begin
          proto_d       = 1'b1;
          acc_d         = samp_mag;
          open_idx_d    = wr_idx;
          open_live_d   = alloc_live;
          open_man_d    = i_man_en;
          open_mshift_d = man_clip;
          if (eop_v) begin
            // The single-sample newcomer takes the finish slot; the
            // interrupted entry stays unready and surfaces as late.
            fin_d        = 1'b1;
            fin_idx_d    = wr_idx;
            fin_live_d   = alloc_live;
            fin_man_d    = i_man_en;
            fin_mshift_d = man_clip;
            fin_acc_d    = samp_mag;
            open_live_d  = 1'b0;
            state_d      = S_IDLE;
          end else begin
            // close the interrupted packet with what it has gathered so far
            fin_d        = 1'b1;
            fin_idx_d    = open_idx_q;
            fin_live_d   = open_live_eff;
            fin_man_d    = open_man_q;
            fin_mshift_d = open_mshift_q;
            fin_acc_d    = acc_q;
          end
        end else if (eop_v) begin
          fin_d        = 1'b1;
          fin_idx_d    = open_idx_q;
          fin_live_d   = open_live_eff;
          fin_man_d    = open_man_q;
          fin_mshift_d = open_mshift_q;
          fin_acc_d    = acc_q | samp_mag;
          open_live_d  = 1'b0;
          state_d      = S_IDLE;
        end else if (i_vld) begin
          acc_d = acc_q | samp_mag;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_IDLE;
      ts_q          <= '0;
      acc_q         <= '0;
      open_idx_q    <= '0;
      open_live_q   <= 1'b0;
      open_man_q    <= 1'b0;
      open_mshift_q <= '0;
      fin_q         <= 1'b0;
      fin_idx_q     <= '0;
      fin_live_q    <= 1'b0;
      fin_man_q     <= 1'b0;
      fin_mshift_q  <= '0;
      fin_acc_q     <= '0;
      q_stamp_q     <= '{default: '0};
      q_shift_q     <= '{default: '0};
      q_rdy_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      shift_num_q   <= '0;
      upd_q         <= 1'b0;
      ovf_q         <= 1'b0;
      late_q        <= 1'b0;
      proto_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      acc_q         <= acc_d;
      open_idx_q    <= open_idx_d;
      open_live_q   <= open_live_d;
      open_man_q    <= open_man_d;
      open_mshift_q <= open_mshift_d;
      fin_q         <= fin_d;
      fin_idx_q     <= fin_idx_d;
      fin_live_q    <= fin_live_d;
      fin_man_q     <= fin_man_d;
      fin_mshift_q  <= fin_mshift_d;
      fin_acc_q     <= fin_acc_d;
      q_stamp_q     <= q_stamp_d;
      q_shift_q     <= q_shift_d;
      q_rdy_q       <= q_rdy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      shift_num_q   <= shift_num_d;
      upd_q         <= upd_d;
      ovf_q         <= ovf_d;
      late_q        <= late_d;
      proto_q       <= proto_d;
    end
  end

  assign o_shift_num = shift_num_q;
  assign o_shift_upd = upd_q;
  assign o_q_level   = level;
  assign o_err_ovf   = ovf_q;
  assign o_err_late  = late_q;
  assign o_err_proto = proto_q;

endmodule

// File: tb/tb_compress_shift_ctrl.sv
// Directed bench for compress_shift_ctrl: peak->shift mapping, due timing, queue and error pulses.
// Latency under test: shift visible DLY_CYCLE+APPLY_OFS = 65 cycles after sop (TSW=7 so stamps wrap).
// Backpressure: none; inputs are driven freely, outputs logged every cycle on the falling edge.
module tb_compress_shift_ctrl;

  localparam int IW = 40;
  localparam logic [IW-1:0] ONES = {IW{1'b1}};
  localparam logic [IW-1:0] ZERO = {IW{1'b0}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
  logic [IW-1:0]   i_din_re = '0, i_din_im = '0;
  logic            i_man_en = 1'b0;
  logic [4:0]      i_man_shift = '0;
  logic [4:0]      o_shift_num;
  logic            o_shift_upd;
  logic [2:0]      o_q_level;
  logic            o_err_ovf, o_err_late, o_err_proto;

  compress_shift_ctrl #(
    .IW(IW), .OW(16), .DLY_CYCLE(64), .APPLY_OFS(1), .QDEPTH(4), .TSW(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im),
    .i_man_en(i_man_en), .i_man_shift(i_man_shift),
    .o_shift_num(o_shift_num), .o_shift_upd(o_shift_upd), .o_q_level(o_q_level),
    .o_err_ovf(o_err_ovf), .o_err_late(o_err_late), .o_err_proto(o_err_proto)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle event log, keyed by cycle number
  int upd_at[int];
  int late_at[int];
  int ovf_at[int];
  int proto_at[int];

  always @(negedge clk) begin
    if (o_shift_upd) upd_at[cyc] = int'(o_shift_num);
    if (o_err_late)  late_at[cyc] = 1;
    if (o_err_ovf)   ovf_at[cyc] = 1;
    if (o_err_proto) proto_at[cyc] = 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  function automatic int upd_val(input int c);
    if (upd_at.exists(c)) return upd_at[c];
    return -1;
  endfunction

  function automatic int cnt_upd(input int lo, input int hi);
    int n = 0;
    foreach (upd_at[k]) if (k >= lo && k <= hi) n++;
    return n;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [IW-1:0] re,
                       input logic [IW-1:0] im, input logic men, input logic [4:0] msh);
    i_sop = sop; i_eop = eop; i_vld = 1'b1;
    i_din_re = re; i_din_im = im;
    i_man_en = men; i_man_shift = msh;
    cyc1();
  endtask

  task automatic idle(input int n);
    i_sop = 1'b0; i_eop = 1'b0; i_vld = 1'b0;
    i_din_re = '0; i_din_im = '0; i_man_en = 1'b0; i_man_shift = '0;
    repeat (n) cyc1();
  endtask

  // len samples; sample sidx carries (sre,sim), the rest (fre,0)
  task automatic pkt(input int len, input int sidx, input logic [IW-1:0] sre,
                     input logic [IW-1:0] sim, input logic [IW-1:0] fre,
                     input logic men, input logic [4:0] msh, output int t);
    t = cyc;
    for (int k = 0; k < len; k++)
      drive(k == 0, k == len - 1, (k == sidx) ? sre : fre, (k == sidx) ? sim : ZERO, men, msh);
    i_sop = 1'b0; i_eop = 1'b0; i_vld = 1'b0;
  endtask

  initial begin
    int t1, ta, tb, tc, tl, tm1, tm2, te, td1, td2, tr1, tr2, tw;
    int t3[5];
    int exp3[4] = '{18, 17, 16, 15};
    logic [IW-1:0] v;

    #2 rst_n = 1'b0;
    repeat (3) cyc1();
    check("rst_shift_num", o_shift_num, 0);
    check("rst_shift_upd", o_shift_upd, 0);
    check("rst_q_level",   o_q_level, 0);
    check("rst_err_ovf",   o_err_ovf, 0);
    check("rst_err_late",  o_err_late, 0);
    check("rst_err_proto", o_err_proto, 0);
    rst_n = 1'b1;
    idle(4);

    // single positive peak -> 14
    pkt(8, 2, 40'h00_0123_4567, ZERO, ZERO, 1'b0, 5'd0, t1);
    idle(70);
    check("p1_upd_early", upd_at.exists(t1 + 64), 0);
    check("p1_shift",     upd_val(t1 + 65), 14);
    check("p1_hold",      o_shift_num, 14);
    check("p1_level",     o_q_level, 0);

    // negative peak, all-zero packet, single-sample packet
    pkt(8, 3, ONES, 40'hFF_8000_0000, ONES, 1'b0, 5'd0, ta);
    pkt(8, 0, ZERO, ZERO, ZERO, 1'b0, 5'd0, tb);
    pkt(1, 0, ONES, ZERO, ONES, 1'b0, 5'd0, tc);
    idle(70);
    check("p2_neg_peak",  upd_val(ta + 65), 8);
    check("p2_zero_pkt",  upd_val(tb + 65), 24);
    check("p2_one_samp",  upd_val(tc + 65), 24);

    // five back-to-back packets into a 4-deep queue
    for (int i = 0; i < 5; i++) begin
      v = ZERO;
      v[20 + i] = 1'b1;
      pkt(4, 1, v, ZERO, ZERO, 1'b0, 5'd0, t3[i]);
    end
    check("q_level_full",  o_q_level, 4);
    check("q_ovf_4th",     ovf_at.exists(t3[3] + 1), 0);
    check("q_ovf_5th",     ovf_at.exists(t3[4] + 1), 1);
    idle(70);
    for (int i = 0; i < 4; i++) check($sformatf("q_upd%0d", i), upd_val(t3[i] + 65), exp3[i]);
    check("q_upd_dropped", upd_at.exists(t3[4] + 65), 0);
    check("q_level_drain", o_q_level, 0);

    // packet longer than the delay -> late
    pkt(70, 0, 40'h10, ZERO, ZERO, 1'b0, 5'd0, tl);
    idle(12);
    check("late_shift",  upd_val(tl + 65), 0);
    check("late_pulse",  late_at.exists(tl + 65), 1);
    check("late_no_upd", cnt_upd(tl + 66, cyc), 0);
    check("late_level",  o_q_level, 0);
    check("late_hold",   o_shift_num, 0);

    // manual override: clipped and pass-through
    pkt(4, 0, 40'h00_0123_4567, ZERO, ZERO, 1'b1, 5'd30, tm1);
    pkt(4, 0, ZERO, ZERO, ZERO, 1'b1, 5'd3, tm2);
    idle(70);
    check("man_clip", upd_val(tm1 + 65), 24);
    check("man_pass", upd_val(tm2 + 65), 3);

    // eop while idle
    te = cyc;
    drive(1'b0, 1'b1, ZERO, ZERO, 1'b0, 5'd0);
    idle(3);
    check("proto_idle_eop", proto_at.exists(te + 1), 1);
    check("proto_idle_lvl", o_q_level, 0);

    // double sop: first packet closed early, both scheduled
    td1 = cyc;
    drive(1'b1, 1'b0, 40'h00_4000_0000, ZERO, 1'b0, 5'd0);
    drive(1'b0, 1'b0, ZERO, ZERO, 1'b0, 5'd0);
    drive(1'b0, 1'b0, ZERO, ZERO, 1'b0, 5'd0);
    td2 = cyc;
    drive(1'b1, 1'b0, 40'h08_0000_0000, ZERO, 1'b0, 5'd0);
    drive(1'b0, 1'b0, ZERO, ZERO, 1'b0, 5'd0);
    drive(1'b0, 1'b1, ZERO, ZERO, 1'b0, 5'd0);
    idle(70);
    check("dsop_no_proto1", proto_at.exists(td1 + 1), 0);
    check("dsop_proto",     proto_at.exists(td2 + 1), 1);
    check("dsop_first",     upd_val(td1 + 65), 8);
    check("dsop_second",    upd_val(td2 + 65), 3);

    // reset mid-packet with entries queued
    pkt(3, 0, ZERO, ZERO, ZERO, 1'b0, 5'd0, tr1);
    pkt(3, 0, ZERO, ZERO, ZERO, 1'b0, 5'd0, tr2);
    drive(1'b1, 1'b0, ZERO, ZERO, 1'b0, 5'd0);
    drive(1'b0, 1'b0, ZERO, ZERO, 1'b0, 5'd0);
    check("rst_pre_level", o_q_level, 3);
    check("rst_pre_shift", o_shift_num, 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_shift", o_shift_num, 0);
    check("arst_level", o_q_level, 0);
    idle(3);
    rst_n = 1'b1;
    idle(80);
    check("arst_no_upd", cnt_upd(tr1, cyc), 0);
    check("arst_level2", o_q_level, 0);

    // timestamp counter wraps before this packet is due
    pkt(4, 0, 40'h00_0200_0000, ZERO, ZERO, 1'b0, 5'd0, tw);
    idle(70);
    check("wrap_early", upd_at.exists(tw + 64), 0);
    check("wrap_shift", upd_val(tw + 65), 13);
    check("wrap_late",  upd_at.exists(tw + 66), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
